pass_next_framer: RTL

//  Parametrised readout framer for the event-camera output path. Each r_next request emits one

---
 rtl/pass_next_framer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pass_next_framer.sv
// rtl/pass_next_framer.sv - round-robin readout framer with tx word; optional frame checksum via PASS_NEXT_CSUM_EN
module pass_next_framer #(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 2,
    parameter int FRAME_LEN   = 1022,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                     clk,
    input  logic                                     res,
    input  logic                                     r_next,
    input  logic                                     new_tx,
    input  logic [NUM_CH*DATA_W-1:0]                 data_in,
    input  logic [DATA_W-1:0]                        data_in_tx,
    output logic [DATA_W-1:0]                        data_out,
    output logic                                     out_valid,
    output logic                                     frame_end,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_idx
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN + 1) : 1;

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
`ifdef PASS_NEXT_CSUM_EN
        S_CSUM = 2'd2,
`endif
        S_TX   = 2'd1
    } state_t;

    logic [SYNC_STAGES-1:0] rn_sync_q;
    logic [SYNC_STAGES-1:0] nt_sync_q;
    logic                   rn_prev_q;
    logic                   nt_prev_q;
    logic                   req_edge;
    logic                   new_edge;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                fend_q, fend_d;

    state_t              state_base;
    logic [CNT_W-1:0]    cnt_base;
    logic [CH_W-1:0]     ch_base;
    logic [DATA_W-1:0]   ch_word;
`ifdef PASS_NEXT_CSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d, csum_base;
`endif

    // Bring the async strobes into clk and keep the previous synchronised level for edge detection
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rn_sync_q <= '0;
            nt_sync_q <= '0;
            rn_prev_q <= 1'b0;
            nt_prev_q <= 1'b0;
        end else begin
            rn_sync_q <= {rn_sync_q[SYNC_STAGES-2:0], r_next};
            nt_sync_q <= {nt_sync_q[SYNC_STAGES-2:0], new_tx};
            rn_prev_q <= rn_sync_q[SYNC_STAGES-1];
            nt_prev_q <= nt_sync_q[SYNC_STAGES-1];
        end
    end

    assign req_edge = rn_sync_q[SYNC_STAGES-1] & ~rn_prev_q;
    assign new_edge = nt_sync_q[SYNC_STAGES-1] & ~nt_prev_q;

    // Framer state register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            ch_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fend_q  <= 1'b0;
`ifdef PASS_NEXT_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fend_q  <= fend_d;
`ifdef PASS_NEXT_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Restart is applied first so a coincident request emits channel 0 of the new frame
    always_comb begin
        state_base = state_q;
        cnt_base   = cnt_q;
        ch_base    = ch_q;
`ifdef PASS_NEXT_CSUM_EN
        csum_base  = csum_q;
`endif
        if (new_edge) begin
            state_base = S_DATA;
            cnt_base   = '0;
            ch_base    = '0;
`ifdef PASS_NEXT_CSUM_EN
            csum_base  = '0;
`endif
        end

        ch_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_base == CH_W'(k)) begin
                ch_word = data_in[k*DATA_W +: DATA_W];
            end
        end

        state_d = state_base;
        cnt_d   = cnt_base;
        ch_d    = ch_base;
        data_d  = data_q;
        valid_d = 1'b0;
        fend_d  = 1'b0;
`ifdef PASS_NEXT_CSUM_EN
        csum_d  = csum_base;
`endif

        if (req_edge) begin
            valid_d = 1'b1;
            case (state_base)
                S_DATA: begin
                    data_d = ch_word;
                    ch_d   = (ch_base == CH_W'(NUM_CH - 1)) ? '0 : ch_base + CH_W'(1);
`ifdef PASS_NEXT_CSUM_EN
                    csum_d = csum_base ^ ch_word;
`endif
                    if (cnt_base == CNT_W'(FRAME_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = S_TX;
                    end else begin
                        cnt_d = cnt_base + CNT_W'(1);
                    end
                end
                S_TX: begin
                    data_d = data_in_tx;
                    ch_d   = '0;
`ifdef PASS_NEXT_CSUM_EN
                    state_d = S_CSUM;
`else
                    fend_d  = 1'b1;
                    state_d = S_DATA;
`endif
                end
`ifdef PASS_NEXT_CSUM_EN
                S_CSUM: begin
                    data_d  = csum_base;
                    fend_d  = 1'b1;
                    csum_d  = '0;
                    state_d = S_DATA;
                end
`endif
                default: begin
                    state_d = S_DATA;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign frame_end = fend_q;
    assign ch_idx    = ch_q;

endmodule
